// File: rtl/multiplicador_pkg.sv
// Shared definitions for the 16x16 shift-and-add multiplier: FSM encoding,
// operand width and iteration count.
package multiplicador_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam int LARGURA   = 16;
  localparam int ITERACOES = 16;

  // Counter value seen on the edge that performs the last partial-product update.
  localparam logic [4:0] ULTIMA_ITERACAO = 5'(ITERACOES - 1);

endpackage

// File: rtl/multiplicador_shift_add_adder.sv
// Existing unsigned ripple adder of the multiplier path: the 17-bit result
// carries the sum in [15:0] and the carry-out in bit 16.
module Adder #(
  parameter int LARGURA = 16
) (
  input  logic [LARGURA-1:0] OperandoA,
  input  logic [LARGURA-1:0] OperandoB,
  output logic [LARGURA:0]   Soma
);

  // Purely combinational sum with carry kept as the MSB.
  always_comb begin
    Soma = {1'b0, OperandoA} + {1'b0, OperandoB};
  end

endmodule

// File: rtl/multiplicador_shift_add.sv
// Sequential unsigned shift-and-add multiplier. P holds {carry+accumulator,
// multiplier}; each CALCULA cycle conditionally adds the multiplicand and
// shifts right by one. The product is captured on the edge that enters FIM.
module multiplicador_shift_add #(
  parameter int LARGURA = 16
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Iniciar,
  input  logic [LARGURA-1:0]     Multiplicando,
  input  logic [LARGURA-1:0]     Multiplicador,
  output logic                   Ocupado,
  output logic                   Pronto,
  output logic [2*LARGURA-1:0]   Produto
);

  import multiplicador_pkg::*;

  estado_t                r_estado;
  estado_t                w_prox_estado;
  logic [LARGURA-1:0]     r_mcand;
  logic [LARGURA-1:0]     w_prox_mcand;
  logic [2*LARGURA:0]     r_p;
  logic [2*LARGURA:0]     w_prox_p;
  logic [4:0]             r_contador;
  logic [4:0]             w_prox_contador;
  logic [2*LARGURA-1:0]   r_produto;
  logic [2*LARGURA-1:0]   w_prox_produto;
  logic                   r_ocupado;
  logic                   r_pronto;
  logic [LARGURA:0]       w_soma;

  // Accumulator plus multiplicand; the carry in w_soma[LARGURA] is always kept.
  Adder #(
    .LARGURA (LARGURA)
  ) u_adder (
    .OperandoA (r_p[2*LARGURA-1:LARGURA]),
    .OperandoB (r_mcand),
    .Soma      (w_soma)
  );

  // Next-state, next-datapath and product-capture logic.
  always_comb begin
    w_prox_estado   = r_estado;
    w_prox_mcand    = r_mcand;
    w_prox_p        = r_p;
    w_prox_contador = r_contador;
    w_prox_produto  = r_produto;
    case (r_estado)
      OCIOSO: begin
        if (Iniciar) begin
          w_prox_estado   = CALCULA;
          w_prox_mcand    = Multiplicando;
          w_prox_p        = {{(LARGURA+1){1'b0}}, Multiplicador};
          w_prox_contador = 5'd0;
        end else begin
          w_prox_estado   = OCIOSO;
        end
      end
      CALCULA: begin
        if (r_p[0]) begin
          w_prox_p = {1'b0, w_soma, r_p[LARGURA-1:1]};
        end else begin
          w_prox_p = {2'b00, r_p[2*LARGURA-1:LARGURA], r_p[LARGURA-1:1]};
        end
        w_prox_contador = r_contador + 5'd1;
        if (r_contador == ULTIMA_ITERACAO) begin
          // Capture here so Produto is already valid while Pronto is high in FIM.
          w_prox_estado  = FIM;
          w_prox_produto = w_prox_p[2*LARGURA-1:0];
        end else begin
          w_prox_estado  = CALCULA;
        end
      end
      FIM: begin
        w_prox_estado = OCIOSO;
      end
      default: begin
        w_prox_estado = OCIOSO;
      end
    endcase
  end

  // State, datapath and registered handshake outputs; reset clears everything.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_estado   <= OCIOSO;
      r_mcand    <= '0;
      r_p        <= '0;
      r_contador <= 5'd0;
      r_produto  <= '0;
      r_ocupado  <= 1'b0;
      r_pronto   <= 1'b0;
    end else begin
      r_estado   <= w_prox_estado;
      r_mcand    <= w_prox_mcand;
      r_p        <= w_prox_p;
      r_contador <= w_prox_contador;
      r_produto  <= w_prox_produto;
      r_ocupado  <= (w_prox_estado == CALCULA) || (w_prox_estado == FIM);
      r_pronto   <= (w_prox_estado == FIM);
    end
  end

  assign Ocupado = r_ocupado;
  assign Pronto  = r_pronto;
  assign Produto = r_produto;

endmodule
